det_stream_arbiter: RTL and testbench

//  Round-robin arbiter sharing one 7-bit character-stream detector (CLK/RST/RDY/DIN[6:0] -> F)

---
 rtl/det_stream_arbiter.sv | 145 ++++++++++++++
 tb/tb_det_stream_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/det_stream_arbiter.sv
// Round-robin arbiter that time-shares one 7-bit character detector among NREQ message sources,
// clearing the detector per message and reporting a sticky per-message flag tagged with the owner.
module det_stream_arbiter #(
  parameter int NREQ  = 4,
  parameter int F_LAT = 1,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NREQ-1:0]   REQ_VLD,
  input  logic [7*NREQ-1:0] REQ_DIN,
  input  logic [NREQ-1:0]   REQ_LAST,
  output logic [NREQ-1:0]   REQ_ACK,
  output logic              DET_RST,
  output logic              DET_RDY,
  output logic [6:0]        DET_DIN,
  input  logic              DET_F,
  output logic              RES_VLD,
  output logic [IDW-1:0]    RES_ID,
  output logic              RES_F,
  output logic              BUSY
);

  typedef enum logic [2:0] {IDLE, CLR, XFER, DRAIN, REPORT} state_t;

  state_t         state;
  logic [IDW-1:0] gnt;
  logic [IDW-1:0] rr_ptr;
  logic [2:0]     cnt;
  logic           sticky;

  logic [IDW-1:0] pick;
  logic           pick_vld;
  logic [IDW:0]   sum;
  logic [IDW-1:0] idx;
  logic           gnt_vld;
  logic           gnt_last;
  logic [6:0]     gnt_din;
  logic           ack;

  // Round-robin search: iterate from the farthest offset down so the nearest hit from rr_ptr wins.
  always_comb begin
    pick     = rr_ptr;
    pick_vld = 1'b0;
    sum      = '0;
    idx      = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      sum = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
      idx = sum[IDW-1:0];
      for (int i = 0; i < NREQ; i++) begin
        if (idx == IDW'(i) && REQ_VLD[i]) begin
          pick     = idx;
          pick_vld = 1'b1;
        end
      end
    end
  end

  // Only the granted lane is looked at, so X on other lanes cannot leak into the datapath.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_last = 1'b0;
    gnt_din  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt == IDW'(i)) begin
        gnt_vld  = REQ_VLD[i];
        gnt_last = REQ_LAST[i];
        gnt_din  = REQ_DIN[7*i +: 7];
      end
    end
  end

  assign ack  = (state == XFER) && gnt_vld;
  assign BUSY = (state != IDLE);

  always_comb begin
    REQ_ACK = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (ack && gnt == IDW'(i)) REQ_ACK[i] = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      gnt     <= '0;
      rr_ptr  <= '0;
      cnt     <= '0;
      sticky  <= 1'b0;
      DET_RST <= 1'b0;
      DET_RDY <= 1'b0;
      DET_DIN <= '0;
      RES_VLD <= 1'b0;
      RES_ID  <= '0;
      RES_F   <= 1'b0;
    end else begin
      DET_RST <= 1'b0;
      DET_RDY <= 1'b0;
      RES_VLD <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            gnt     <= pick;
            DET_RST <= 1'b1;
            state   <= CLR;
          end
        end
        CLR: begin
          sticky <= 1'b0;
          state  <= XFER;
        end
        XFER: begin
          sticky <= sticky | DET_F;
          if (ack) begin
            DET_RDY <= 1'b1;
            DET_DIN <= gnt_din;
            if (gnt_last) begin
              cnt   <= 3'(F_LAT);
              state <= DRAIN;
            end
          end
        end
        // First DRAIN cycle carries the last strobe; the final one folds DET_F straight into RES_F.
        DRAIN: begin
          sticky <= sticky | DET_F;
          if (cnt == 3'd0) begin
            RES_VLD <= 1'b1;
            RES_ID  <= gnt;
            RES_F   <= sticky | DET_F;
            state   <= REPORT;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        REPORT: begin
          rr_ptr <= (gnt == IDW'(NREQ - 1)) ? '0 : gnt + 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_det_stream_arbiter.sv
// Directed bench for det_stream_arbiter: one instance with F_LAT=1 for arbitration and message
// flow, a second with F_LAT=2 for the drain sampling window.
module tb_det_stream_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  vld, last, ack, vld2, last2, ack2;
  logic [27:0] din, din2;
  logic        det_rst, det_rdy, res_vld, res_f, busy;
  logic        det_rst2, det_rdy2, res_vld2, res_f2, busy2;
  logic        det_f = 1'b0;
  logic        det_f2;
  logic [6:0]  det_din, det_din2;
  logic [1:0]  res_id, res_id2;

  int          n_cmp = 0;
  int          n_err = 0;
  bit          f_mode = 1'b0;
  bit          watch1 = 1'b0;
  int          ack1_bad = 0;
  int          rst_pulses = 0;
  int          rdy_pulses = 0;
  logic [2:0]  res_log[$];

  det_stream_arbiter u_dut (
    .CLK(clk), .RST(rst), .REQ_VLD(vld), .REQ_DIN(din), .REQ_LAST(last), .REQ_ACK(ack),
    .DET_RST(det_rst), .DET_RDY(det_rdy), .DET_DIN(det_din), .DET_F(det_f),
    .RES_VLD(res_vld), .RES_ID(res_id), .RES_F(res_f), .BUSY(busy)
  );

  det_stream_arbiter #(.NREQ(4), .F_LAT(2), .IDW(2)) u_dut2 (
    .CLK(clk), .RST(rst), .REQ_VLD(vld2), .REQ_DIN(din2), .REQ_LAST(last2), .REQ_ACK(ack2),
    .DET_RST(det_rst2), .DET_RDY(det_rdy2), .DET_DIN(det_din2), .DET_F(det_f2),
    .RES_VLD(res_vld2), .RES_ID(res_id2), .RES_F(res_f2), .BUSY(busy2)
  );

  always #5 clk = ~clk;

  // Detector stand-in: flags one cycle after it is strobed with 'C'.
  always @(posedge clk) det_f <= f_mode && det_rdy && (det_din == 7'h43);

  always @(negedge clk) begin
    if (res_vld === 1'b1) res_log.push_back({res_id, res_f});
    if (det_rst === 1'b1) rst_pulses++;
    if (det_rdy === 1'b1) rdy_pulses++;
    if (watch1 && ack[1] !== 1'b0) ack1_bad++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a char on a lane and hold it until ACKed; returns one cycle after the ACK edge.
  task automatic put(input bit d2, input int lane, input logic [6:0] ch, input logic lst);
    bit got = 1'b0;
    if (d2) begin
      vld2[lane] = 1'b1; din2[7*lane +: 7] = ch; last2[lane] = lst;
    end else begin
      vld[lane] = 1'b1; din[7*lane +: 7] = ch; last[lane] = lst;
    end
    for (int i = 0; i < 60; i++) begin
      #1;
      got = d2 ? (ack2[lane] === 1'b1) : (ack[lane] === 1'b1);
      @(posedge clk);
      #1;
      if (got) break;
    end
    chk("ack_wait", got, 1'b1);
    if (d2) begin
      vld2[lane] = 1'b0; last2[lane] = 1'b0;
    end else begin
      vld[lane] = 1'b0; last[lane] = 1'b0;
    end
  endtask

  task automatic wait_log(input int n);
    for (int i = 0; i < 100; i++) begin
      if (res_log.size() >= n) break;
      step();
    end
    chk("res_wait", res_log.size() >= n, 1'b1);
  endtask

  task automatic check_res(input string tag, input logic [1:0] id, input logic f);
    logic [2:0] e;
    e = 3'bxxx;
    if (res_log.size() > 0) e = res_log.pop_front();
    chk({tag, "_id"}, e[2:1], id);
    chk({tag, "_f"}, e[0], f);
  endtask

  initial begin
    vld = '0; last = '0; din = '0;
    vld2 = '0; last2 = '0; din2 = '0; det_f2 = 1'b0;

    // Reset held three cycles with nothing requesting
    rst = 1'b1;
    repeat (3) begin
      step();
      chk("rst_busy", busy, 1'b0);
      chk("rst_rdy", det_rdy, 1'b0);
      chk("rst_ack", ack, 4'h0);
      chk("rst_resvld", res_vld, 1'b0);
    end
    chk("rst_detrst", det_rst, 1'b0);
    chk("rst_detdin", det_din, 7'h00);
    chk("rst_resid", res_id, 2'd0);
    chk("rst_resf", res_f, 1'b0);
    chk("rst_busy2", busy2, 1'b0);
    rst = 1'b0;
    step();
    chk("idle_busy", busy, 1'b0);
    chk("idle_nores", res_log.size(), 0);

    // Req0: A, B, C back-to-back, detector flags on C
    f_mode = 1'b1;
    vld[0] = 1'b1; din[6:0] = 7'h41; last[0] = 1'b0;
    #1 chk("t2_ack_idle", ack, 4'h0);
    step();
    chk("t2_clr_detrst", det_rst, 1'b1);
    chk("t2_clr_busy", busy, 1'b1);
    chk("t2_clr_ack", ack, 4'h0);
    step();
    chk("t2_x_detrst", det_rst, 1'b0);
    chk("t2_x_ack", ack, 4'h1);
    step();
    din[6:0] = 7'h42;
    chk("t2_rdy1", det_rdy, 1'b1);
    chk("t2_din1", det_din, 7'h41);
    #1 chk("t2_ack2", ack, 4'h1);
    step();
    din[6:0] = 7'h43; last[0] = 1'b1;
    chk("t2_rdy2", det_rdy, 1'b1);
    chk("t2_din2", det_din, 7'h42);
    step();
    vld[0] = 1'b0; last[0] = 1'b0;
    chk("t2_rdy3", det_rdy, 1'b1);
    chk("t2_din3", det_din, 7'h43);
    #1 chk("t2_ack_drain", ack, 4'h0);
    step();
    chk("t2_rdy_end", det_rdy, 1'b0);
    chk("t2_din_hold", det_din, 7'h43);
    chk("t2_noresyet", res_vld, 1'b0);
    step();
    chk("t2_resvld", res_vld, 1'b1);
    chk("t2_resid", res_id, 2'd0);
    chk("t2_resf", res_f, 1'b1);
    step();
    chk("t2_res_pulse", res_vld, 1'b0);
    chk("t2_resf_hold", res_f, 1'b1);
    chk("t2_idle", busy, 1'b0);
    chk("t2_rst_pulses", rst_pulses, 1);
    chk("t2_rdy_pulses", rdy_pulses, 3);
    res_log.delete();

    // Req1 single-char message; sticky must start cleared
    f_mode = 1'b0;
    put(1'b0, 1, 7'h15, 1'b1);
    wait_log(1);
    check_res("t2b", 2'd1, 1'b0);
    step();

    // Req1 and Req3 together with rr_ptr at 2: Req3 first, Req1 waits unACKed
    watch1 = 1'b1;
    vld[1] = 1'b1; din[13:7] = 7'h31; last[1] = 1'b1;
    put(1'b0, 3, 7'h33, 1'b0);
    put(1'b0, 3, 7'h34, 1'b1);
    wait_log(1);
    watch1 = 1'b0;
    chk("t3_req1_held", ack1_bad, 0);
    check_res("t3a", 2'd3, 1'b0);
    put(1'b0, 1, 7'h31, 1'b1);
    wait_log(1);
    check_res("t3b", 2'd1, 1'b0);
    step();

    // Req2 with a three-cycle gap between chars
    put(1'b0, 2, 7'h61, 1'b0);
    chk("t4_rdy_a", det_rdy, 1'b1);
    chk("t4_din_a", det_din, 7'h61);
    step();
    chk("t4_gap1", det_rdy, 1'b0);
    step();
    chk("t4_gap2", det_rdy, 1'b0);
    step();
    chk("t4_gap3", det_rdy, 1'b0);
    chk("t4_gap_busy", busy, 1'b1);
    put(1'b0, 2, 7'h62, 1'b1);
    chk("t4_rdy_b", det_rdy, 1'b1);
    chk("t4_din_b", det_din, 7'h62);
    wait_log(1);
    check_res("t4", 2'd2, 1'b0);
    step();

    // F_LAT=2: pulse on the last sampled cycle counts, one cycle later does not
    put(1'b1, 0, 7'h10, 1'b1);
    chk("t5_rdy", det_rdy2, 1'b1);
    step();
    step();
    chk("t5_drain_long", res_vld2, 1'b0);
    det_f2 = 1'b1;
    step();
    det_f2 = 1'b0;
    chk("t5a_resvld", res_vld2, 1'b1);
    chk("t5a_resid", res_id2, 2'd0);
    chk("t5a_resf", res_f2, 1'b1);
    step();
    chk("t5a_idle", busy2, 1'b0);
    put(1'b1, 1, 7'h11, 1'b1);
    step();
    step();
    step();
    det_f2 = 1'b1;
    #1;
    chk("t5b_resvld", res_vld2, 1'b1);
    chk("t5b_resid", res_id2, 2'd1);
    chk("t5b_resf", res_f2, 1'b0);
    step();
    det_f2 = 1'b0;

    // Reset in the middle of a Req3 message, then retry alongside Req1
    put(1'b0, 3, 7'h71, 1'b0);
    put(1'b0, 3, 7'h72, 1'b0);
    chk("t6_pre_busy", busy, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_busy", busy, 1'b0);
    chk("t6_rdy", det_rdy, 1'b0);
    chk("t6_resvld", res_vld, 1'b0);
    repeat (3) step();
    chk("t6_nores", res_log.size(), 0);
    vld[1] = 1'b1; din[13:7] = 7'h11; last[1] = 1'b1;
    put(1'b0, 3, 7'h71, 1'b0);
    put(1'b0, 3, 7'h72, 1'b1);
    wait_log(2);
    check_res("t6a", 2'd1, 1'b0);
    check_res("t6b", 2'd3, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
